// File: rtl/fifo_rd_framer.sv
// rtl/fifo_rd_framer.sv - Read-side FIFO consumer emitting SYNC/sequence/payload frames on a ready/valid stream
module fifo_rd_framer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FRAME_LEN  = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 8'hA5,
    parameter int                    CNT_WIDTH  = 8
) (
    input  logic                  rdclk,
    input  logic                  PresetFull,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_rdempty,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic [CNT_WIDTH-1:0]  frame_seq,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] LEN  = CNT_WIDTH'(FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, BODY} state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    popped;
    logic                    inflight;
    logic                    inflight_last;
    logic                    spare_valid;
    logic [DATA_WIDTH-1:0]   spare_data;
    logic                    spare_eof;
    logic                    xfer;
    logic [1:0]              occ;
    logic [2:0]              pending;

    // The output register is the skid head; spare_* is the second entry.
    assign xfer       = m_valid & m_ready;
    assign occ        = {1'b0, m_valid} + {1'b0, spare_valid};
    assign pending    = {1'b0, occ} + {2'b0, inflight};
    assign fifo_rdreq = (state == BODY) && !fifo_rdempty && (popped < LEN)
                        && (pending < (3'd2 + {2'b0, xfer}));
    assign busy       = (state != IDLE);

    always_ff @(posedge rdclk or posedge PresetFull) begin
        if (PresetFull) begin
            state         <= IDLE;
            popped        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            spare_valid   <= 1'b0;
            spare_data    <= '0;
            spare_eof     <= 1'b0;
            m_data        <= '0;
            m_valid       <= 1'b0;
            m_sof         <= 1'b0;
            m_eof         <= 1'b0;
            frame_seq     <= '0;
        end else begin
            inflight      <= fifo_rdreq;
            inflight_last <= fifo_rdreq && (popped == LAST);
            if (fifo_rdreq) begin
                popped <= popped + 1'b1;
            end
            case (state)
                IDLE: begin
                    popped <= '0;
                    if (enable && !fifo_rdempty) begin
                        state   <= HDR;
                        m_valid <= 1'b1;
                        m_data  <= SYNC_WORD;
                        m_sof   <= 1'b1;
                        m_eof   <= 1'b0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state  <= SEQ;
                        m_data <= DATA_WIDTH'(frame_seq);
                        m_sof  <= 1'b0;
                    end
                end
                SEQ: begin
                    if (xfer) begin
                        state   <= BODY;
                        m_valid <= 1'b0;
                    end
                end
                BODY: begin
                    if (xfer && m_eof) begin
                        // Pop rule guarantees nothing is buffered or in flight here.
                        state     <= IDLE;
                        m_valid   <= 1'b0;
                        m_eof     <= 1'b0;
                        frame_seq <= frame_seq + 1'b1;
                    end else if (xfer || !m_valid) begin
                        if (spare_valid) begin
                            m_data      <= spare_data;
                            m_eof       <= spare_eof;
                            m_valid     <= 1'b1;
                            spare_valid <= inflight;
                            spare_data  <= fifo_q;
                            spare_eof   <= inflight_last;
                        end else if (inflight) begin
                            m_data  <= fifo_q;
                            m_eof   <= inflight_last;
                            m_valid <= 1'b1;
                        end else begin
                            m_valid <= 1'b0;
                            m_eof   <= 1'b0;
                        end
                    end else if (inflight) begin
                        spare_valid <= 1'b1;
                        spare_data  <= fifo_q;
                        spare_eof   <= inflight_last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_framer.sv
// tb/tb_fifo_rd_framer.sv - Scoreboard bench for fifo_rd_framer with a queue-based FIFO and frame model
module tb_fifo_rd_framer;

    localparam int FL = 16;

    logic       rdclk = 1'b0;
    logic       PresetFull = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_rdempty = 1'b1;
    logic       fifo_rdreq;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_sof;
    logic       m_eof;
    logic [7:0] frame_seq;
    logic       busy;

    fifo_rd_framer #(
        .DATA_WIDTH(8),
        .FRAME_LEN (FL),
        .SYNC_WORD (8'hA5),
        .CNT_WIDTH (8)
    ) dut (
        .rdclk       (rdclk),
        .PresetFull  (PresetFull),
        .enable      (enable),
        .fifo_q      (fifo_q),
        .fifo_rdempty(fifo_rdempty),
        .fifo_rdreq  (fifo_rdreq),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eof       (m_eof),
        .frame_seq   (frame_seq),
        .busy        (busy)
    );

    always #5 rdclk = ~rdclk;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fifo_mem[$];
    logic [7:0] pend_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         force_empty = 1'b0;
    int         rdy_mode = 1;
    logic [7:0] seq_model = 8'h00;
    int         frame_beat = -1;
    int         pay0_cyc = 0;
    int         eof_cyc = 0;
    bit         hold = 1'b0;
    logic [9:0] held;
    beat_t      e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge rdclk) cyc++;

    // Downstream ready pattern: 0 hold-off, 1 always, 2 toggle, 3 random ~75%.
    initial forever begin
        @(posedge rdclk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = ~m_ready;
            default: m_ready = ($urandom_range(3) != 0);
        endcase
    end

    // Show-ahead-free FIFO: a pop seen at an edge presents its word just after that edge.
    initial forever begin
        bit pop;
        @(posedge rdclk);
        pop = fifo_rdreq && !PresetFull;
        #1;
        if (pop && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
        fifo_rdempty = (fifo_mem.size() == 0) || force_empty;
    end

    initial forever begin
        @(negedge rdclk);
        if (PresetFull) begin
            hold = 1'b0;
            frame_beat = -1;
        end else begin
            if (hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_beat", {m_data, m_sof, m_eof}, held);
            end
            if (fifo_rdreq) chk("rdreq_while_empty", fifo_rdempty, 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", {m_data, m_sof, m_eof});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_data, m_sof, m_eof}, {e.d, e.sof, e.eof});
                end
                if (m_sof) frame_beat = 0;
                else if (frame_beat >= 0) frame_beat++;
                if (frame_beat == 2) pay0_cyc = cyc;
                if (m_eof) begin
                    eof_cyc = cyc;
                    frame_beat = -1;
                end
            end
            hold = m_valid && !m_ready;
            held = {m_data, m_sof, m_eof};
        end
    end

    task automatic step();
        @(posedge rdclk);
        #2;
    endtask

    task automatic load_frame(input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < FL; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            fifo_mem.push_back(b);
            pend_q.push_back(b);
        end
    endtask

    task automatic expect_frame();
        exp_q.push_back('{d: 8'hA5, sof: 1'b1, eof: 1'b0});
        exp_q.push_back('{d: seq_model, sof: 1'b0, eof: 1'b0});
        for (int i = 0; i < FL; i++)
            exp_q.push_back('{d: pend_q.pop_front(), sof: 1'b0, eof: (i == FL - 1)});
        seq_model = seq_model + 8'd1;
    endtask

    task automatic wait_pay(input int idx);
        int n = 0;
        while ((frame_beat - 2) < idx && n < 2000) begin
            @(negedge rdclk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_pay timeout actual=%0d required=%0d", frame_beat - 2, idx);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || m_valid) && n < budget) begin
            @(negedge rdclk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout actual=%0d required=0 pending beats", exp_q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_sof_eof"}, {m_sof, m_eof}, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_seq"}, frame_seq, 0);
        chk({tag, "_rdreq"}, fifo_rdreq, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset applied between clock edges must act immediately.
        #3 PresetFull = 1'b1;
        #1 chk_reset_outputs("rst");
        @(posedge rdclk);
        #3 PresetFull = 1'b0;

        // Ramp payload, full rate.
        load_frame(1'b0);
        expect_frame();
        step();
        enable = 1'b1;
        wait_idle(500);
        chk("rate_span", eof_cyc - pay0_cyc, FL - 1);
        chk("seq_after_first", frame_seq, seq_model);

        // Toggling ready, then a long stall that fills the skid buffer.
        rdy_mode = 2;
        load_frame(1'b1);
        expect_frame();
        wait_pay(6);
        step();
        rdy_mode = 0;
        repeat (5) step();
        @(negedge rdclk);
        chk("stall_rdreq_off", fifo_rdreq, 0);
        chk("stall_valid_held", m_valid, 1);
        rdy_mode = 1;
        wait_idle(500);
        chk("seq_after_stall", frame_seq, seq_model);

        // FIFO runs dry mid-payload.
        load_frame(1'b1);
        expect_frame();
        wait_pay(5);
        step();
        force_empty = 1'b1;
        repeat (10) step();
        @(negedge rdclk);
        chk("empty_drained", m_valid, 0);
        chk("empty_still_busy", busy, 1);
        force_empty = 1'b0;
        wait_idle(500);

        // Enable dropped mid-frame: finish it, then stay idle with data waiting.
        load_frame(1'b1);
        expect_frame();
        wait_pay(2);
        step();
        enable = 1'b0;
        load_frame(1'b1);
        wait_idle(500);
        repeat (5) step();
        chk("disabled_idle", busy, 0);
        chk("disabled_fifo_kept", fifo_mem.size(), FL);
        chk("seq_before_disable", frame_seq, seq_model);
        expect_frame();
        enable = 1'b1;
        wait_idle(500);

        // Reset mid-payload abandons the frame; sequence restarts.
        load_frame(1'b1);
        expect_frame();
        wait_pay(7);
        @(posedge rdclk);
        #3 PresetFull = 1'b1;
        #1 chk_reset_outputs("midrst");
        fifo_mem.delete();
        exp_q.delete();
        pend_q.delete();
        seq_model = 8'h00;
        load_frame(1'b1);
        expect_frame();
        @(posedge rdclk);
        #3 PresetFull = 1'b0;
        wait_idle(500);
        chk("seq_after_midrst", frame_seq, seq_model);

        // 256 back-to-back frames with random backpressure: sequence wraps.
        rdy_mode = 3;
        for (int f = 0; f < 256; f++) load_frame(1'b1);
        for (int f = 0; f < 256; f++) expect_frame();
        wait_idle(20000);
        chk("seq_after_wrap", frame_seq, seq_model);
        chk("fifo_drained", fifo_mem.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
